// File: rtl/uart_host_pkg.sv
// Shared types and constants for the host-side UART transmitter and its FIFO.
package uart_host_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int unsigned DATA_BITS = 8;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_host_fifo.sv
// Synchronous show-ahead FIFO with registered FULL/EMPTY/COUNT flags.
module uart_host_fifo
   import uart_host_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            WR_EN,
   input  logic [WIDTH-1:0]                WR_DATA,
   input  logic                            RD_EN,
   output logic [WIDTH-1:0]                RD_DATA,
   output logic                            FULL,
   output logic                            EMPTY,
   output logic [count_width(DEPTH)-1:0]   COUNT
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = count_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_d;
   logic             wr_ok_c;
   logic             rd_ok_c;

   // A write while full is refused even if a pop frees a slot this cycle.
   assign wr_ok_c = WR_EN && !FULL;
   assign rd_ok_c = RD_EN && !EMPTY;
   assign RD_DATA = mem[rd_ptr_q];

   always_comb begin
      count_d = COUNT;
      if (wr_ok_c && !rd_ok_c) begin
         count_d = COUNT + CNT_W'(1);
      end else if (rd_ok_c && !wr_ok_c) begin
         count_d = COUNT - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_ok_c) begin
         mem[wr_ptr_q] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         COUNT    <= '0;
         FULL     <= 1'b0;
         EMPTY    <= 1'b1;
      end else begin
         if (wr_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (rd_ok_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         COUNT <= count_d;
         FULL  <= (count_d == CNT_W'(DEPTH));
         EMPTY <= (count_d == '0);
      end
   end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side 8N1 UART transmitter (LSB first) fed from a small write FIFO.
module uart_host_tx
   import uart_host_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                                 CLK,
   input  logic                                 RESET,
   input  logic                                 WR_EN,
   input  logic [DATA_BITS-1:0]                 WR_DATA,
   output logic                                 FULL,
   output logic [count_width(FIFO_DEPTH)-1:0]   COUNT,
   output logic                                 OVERRUN,
   output logic                                 BUSY,
   output logic                                 TX_DONE,
   output logic                                 TXD
);

   localparam int unsigned DIV_W = $clog2(STOP_BITS * CLK_DIV);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] STOP_LAST = DIV_W'(STOP_BITS * CLK_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 txd_d;
   logic                 pop_c;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rd_data;

   uart_host_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .WR_EN   (WR_EN),
      .WR_DATA (WR_DATA),
      .RD_EN   (pop_c),
      .RD_DATA (fifo_rd_data),
      .FULL    (FULL),
      .EMPTY   (fifo_empty),
      .COUNT   (COUNT)
   );

   // Next-state, divider, shifter and line level.
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bitcnt_d = bitcnt_q;
      sh_d     = sh_q;
      txd_d    = TXD;
      pop_c    = 1'b0;

      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (!fifo_empty) begin
               pop_c   = 1'b1;
               sh_d    = fifo_rd_data;
               div_d   = BIT_LAST;
               txd_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (div_q == '0) begin
               txd_d    = sh_q[0];
               bitcnt_d = '0;
               div_d    = BIT_LAST;
               state_d  = DATA;
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end
         DATA: begin
            if (div_q == '0) begin
               if (bitcnt_q == LAST_BIT) begin
                  txd_d   = 1'b1;
                  div_d   = STOP_LAST;
                  state_d = STOP;
               end else begin
                  sh_d     = sh_q >> 1;
                  txd_d    = sh_q[1];
                  bitcnt_d = bitcnt_q + BIT_W'(1);
                  div_d    = BIT_LAST;
               end
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end
         STOP: begin
            if (div_q == '0) begin
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  pop_c   = 1'b1;
                  sh_d    = fifo_rd_data;
                  div_d   = BIT_LAST;
                  txd_d   = 1'b0;
                  state_d = START;
               end else begin
                  txd_d   = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               div_d = div_q - DIV_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bitcnt_q <= '0;
         sh_q     <= '0;
         TXD      <= 1'b1;
         BUSY     <= 1'b0;
         TX_DONE  <= 1'b0;
         OVERRUN  <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bitcnt_q <= bitcnt_d;
         sh_q     <= sh_d;
         TXD      <= txd_d;
         BUSY     <= (state_d != IDLE);
         // High during the last cycle of the final stop bit.
         TX_DONE  <= (state_d == STOP) && (div_d == '0);
         OVERRUN  <= WR_EN && FULL;
      end
   end

endmodule

// File: tb/tb_uart_host_tx.sv
// Randomized scoreboard bench for uart_host_tx across three parameter sets.
module tb_uart_host_tx;

   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0] data;
      int         start;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   int         sel = 0;
   int         cyc = 0;

   int checks = 0;
   int errors = 0;

   logic       full0, ovr0, busy0, done0, txd0;
   logic       full1, ovr1, busy1, done1, txd1;
   logic       full2, ovr2, busy2, done2, txd2;
   logic [2:0] count0, count1, count2;

   logic       m_full, m_ovr, m_busy, m_done, m_txd;
   logic [2:0] m_count;

   // Model state and per-edge predictions
   logic [7:0] pending[$];
   exp_t       exp_q[$];
   int         cd = 16, sb = 1, flen = 160;
   int         free_edge = 0;
   int         last_pop = 0;
   int         pred_count = 0;
   logic       pred_full = 1'b0, pred_busy = 1'b0, pred_ovr = 1'b0, pred_done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_host_tx #(.CLK_DIV(16), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut0 (
      .CLK(clk), .RESET(rst || sel != 0), .WR_EN(wr_en && sel == 0), .WR_DATA(wr_data),
      .FULL(full0), .COUNT(count0), .OVERRUN(ovr0), .BUSY(busy0), .TX_DONE(done0), .TXD(txd0));

   uart_host_tx #(.CLK_DIV(16), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut1 (
      .CLK(clk), .RESET(rst || sel != 1), .WR_EN(wr_en && sel == 1), .WR_DATA(wr_data),
      .FULL(full1), .COUNT(count1), .OVERRUN(ovr1), .BUSY(busy1), .TX_DONE(done1), .TXD(txd1));

   uart_host_tx #(.CLK_DIV(2), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut2 (
      .CLK(clk), .RESET(rst || sel != 2), .WR_EN(wr_en && sel == 2), .WR_DATA(wr_data),
      .FULL(full2), .COUNT(count2), .OVERRUN(ovr2), .BUSY(busy2), .TX_DONE(done2), .TXD(txd2));

   always_comb begin
      case (sel)
         1:       {m_full, m_count, m_ovr, m_busy, m_done, m_txd} = {full1, count1, ovr1, busy1, done1, txd1};
         2:       {m_full, m_count, m_ovr, m_busy, m_done, m_txd} = {full2, count2, ovr2, busy2, done2, txd2};
         default: {m_full, m_count, m_ovr, m_busy, m_done, m_txd} = {full0, count0, ovr0, busy0, done0, txd0};
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (sel %0d edge %0d): got %0h expected %0h", name, sel, cyc, act, exp);
      end
   endtask

   // Reference model: what the coming edge does to the queue and the line.
   task automatic model_step(input logic w, input logic [7:0] d, input logic r);
      int   n;
      int   sz;
      logic [7:0] b;
      n  = cyc + 1;
      sz = pending.size();
      if (r) begin
         pending.delete();
         free_edge = n;
         pred_ovr  = 1'b0;
      end else begin
         pred_ovr = w && (sz >= DEPTH);
         if (sz > 0 && n >= free_edge) begin
            b = pending.pop_front();
            exp_q.push_back('{data: b, start: n});
            free_edge = n + flen;
            last_pop  = n;
         end
         if (w && sz < DEPTH) pending.push_back(d);
      end
      pred_count = pending.size();
      pred_full  = (pending.size() == DEPTH);
      pred_busy  = (n < free_edge);
      pred_done  = (n == free_edge - 1);
   endtask

   task automatic cyc_drive(input logic w, input logic [7:0] d, input logic r);
      @(negedge clk);
      wr_en   = w;
      wr_data = d;
      rst     = r;
      model_step(w, d, r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_drive(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((pending.size() != 0 || cyc < free_edge) && guard < 20000) begin
         idle(1);
         guard++;
      end
      if (guard >= 20000) check("drain_timeout", 32'(guard), 32'd0);
      idle(3);
   endtask

   task automatic switch_to(input int k, input int div, input int stops);
      @(negedge clk);
      sel     = k;
      cd      = div;
      sb      = stops;
      flen    = (9 + stops) * div;
      wr_en   = 1'b0;
      rst     = 1'b1;
      model_step(1'b0, 8'h00, 1'b1);
   endtask

   task automatic random_traffic(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3 * flen));
         else cyc_drive(1'b1, 8'($urandom), 1'b0);
      end
      drain();
   endtask

   // Monitor: status outputs every cycle, plus a UART decoder for TXD.
   initial begin : monitor
      logic       in_frame;
      int         j, b, k;
      logic [7:0] rx;
      logic       ok, lvl;
      exp_t       cur;
      in_frame = 1'b0;
      j = 0; rx = 8'h00; ok = 1'b1;
      cur = '{data: 8'h00, start: -1};
      forever begin
         @(posedge clk);
         #1;
         check("count",   32'(m_count), 32'(pred_count));
         check("full",    32'(m_full),  32'(pred_full));
         check("busy",    32'(m_busy),  32'(pred_busy));
         check("overrun", 32'(m_ovr),   32'(pred_ovr));
         check("tx_done", 32'(m_done),  32'(pred_done));
         if (rst) begin
            in_frame = 1'b0;
            check("txd_reset", 32'(m_txd), 32'd1);
         end else begin
            if (!in_frame) begin
               if (m_txd === 1'b0) begin
                  in_frame = 1'b1;
                  j  = 0;
                  ok = 1'b1;
                  rx = 8'h00;
                  check("start_expected", 32'(exp_q.size() > 0), 32'd1);
                  if (exp_q.size() > 0) cur = exp_q.pop_front();
                  else cur = '{data: 8'h00, start: -1};
                  check("start_edge", 32'(cyc), 32'(cur.start));
               end
            end else begin
               j++;
            end
            if (in_frame) begin
               b = j / cd;
               k = j % cd;
               if (b >= 1 && b <= 8 && k == 0) rx[b-1] = m_txd;
               if (b == 0)      lvl = 1'b0;
               else if (b <= 8) lvl = rx[b-1];
               else             lvl = 1'b1;
               if (m_txd !== lvl) ok = 1'b0;
               if (j == flen - 1) begin
                  check("data", 32'(rx), 32'(cur.data));
                  check("bit_shape", 32'(ok), 32'd1);
                  in_frame = 1'b0;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete, edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int t;
      int n;
      cyc_drive(1'b0, 8'h00, 1'b1);
      idle(3);

      // Single byte from idle
      cyc_drive(1'b1, 8'hA5, 1'b0);
      drain();

      // Burst of six into a four-deep FIFO: last one overruns
      for (int i = 1; i <= 6; i++) cyc_drive(1'b1, 8'(i), 1'b0);
      drain();

      // Keep the FIFO topped up through pointer wrap
      n = 0;
      while (n < 10) begin
         if (pending.size() < DEPTH) begin
            cyc_drive(1'b1, 8'(n), 1'b0);
            n++;
         end else begin
            idle(1);
         end
      end
      drain();

      // Reset in the 4th data bit of 0xFF with two bytes queued
      cyc_drive(1'b1, 8'hFF, 1'b0);
      cyc_drive(1'b1, 8'h11, 1'b0);
      cyc_drive(1'b1, 8'h22, 1'b0);
      t = last_pop + 16 + 3 * 16 + 8;
      while (cyc + 1 < t) idle(1);
      cyc_drive(1'b0, 8'h00, 1'b1);
      idle(400);

      random_traffic(40);

      // Two stop bits
      switch_to(1, 16, 2);
      idle(2);
      cyc_drive(1'b1, 8'h3C, 1'b0);
      drain();
      random_traffic(10);

      // Minimum divider
      switch_to(2, 2, 1);
      idle(2);
      cyc_drive(1'b1, 8'h55, 1'b0);
      cyc_drive(1'b1, 8'hAA, 1'b0);
      drain();
      random_traffic(30);

      idle(5);
      check("leftover_frames", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_host_tx.md
Name: uart_host_tx

Overview:
- Synthesizable host-side UART transmitter, 8N1, LSB first, with a small write FIFO.
- Drives the SoC's UART_RXD pin so directed tests and the FPGA loopback harness can send byte streams into the SoC UART receiver.
- It is the counterpart of the SoC's UART transmit path, sitting outside AHBLITE_SYS in the bench and the board top.

Parameters:
- CLK_DIV, 16: CLK cycles per bit. Legal range 2..65535.
- FIFO_DEPTH, 4: entries in the write FIFO. Power of two, 2..16.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- CLK  in  1: system clock, rising edge.
- RESET  in  1: synchronous, active-high reset.
- WR_EN  in  1: write request; the byte is accepted on a rising edge when FULL=0.
- WR_DATA  in  8: byte to transmit.
- FULL  out  1: FIFO count equals FIFO_DEPTH.
- COUNT  out  $clog2(FIFO_DEPTH)+1: bytes queued, excluding the byte currently on the line.
- OVERRUN  out  1: one-cycle pulse when WR_EN=1 while FULL=1; that byte is dropped.
- BUSY  out  1: high in every state except IDLE.
- TX_DONE  out  1: one-cycle pulse in the final cycle of the last stop bit.
- TXD  out  1: serial output, idles high.

Behaviour:
- Reset (RESET=1 at a rising edge) sets:
  - TXD=1, BUSY=0, FULL=0, COUNT=0, OVERRUN=0, TX_DONE=0.
  - FIFO pointers cleared, state IDLE, bit counter and divider cleared.
- Reset mid-frame aborts the frame. TXD=1 from the next edge, and all queued bytes are discarded.
- All outputs are registered.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
  - A write with FULL=1 is dropped and OVERRUN pulses, even if a pop happens in the same cycle.
  - A write and a pop in the same cycle leave COUNT unchanged.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - If COUNT>0: pop the head into shift register sh[7:0], load the divider with CLK_DIV-1, and go to START. TXD=0 from the same edge.
  - If COUNT=0: stay in IDLE.
  - A byte written at edge k into an empty FIFO with the FSM in IDLE gives COUNT=1 after k and TXD=0 after edge k+1. First-write-to-start-bit latency is 2 edges.
- Divider: down-counter. Each bit lasts exactly CLK_DIV cycles. The bit ends in the cycle where the divider is 0.
- START: at the end of the bit, TXD<=sh[0], bitcnt<=0, go to DATA.
- DATA:
  - At the end of each bit, shift sh right and increment bitcnt.
  - When bitcnt==7 at the end of the bit: TXD<=1 and go to STOP.
  - Data goes out LSB first.
- STOP:
  - Lasts STOP_BITS*CLK_DIV cycles with TXD=1.
  - TX_DONE is asserted in the final cycle.
  - At the end: if COUNT>0, pop and go straight to START with no idle gap (TXD=0 at the next edge). Otherwise go to IDLE.
- Frame length is exactly (9+STOP_BITS)*CLK_DIV cycles. Back-to-back frames have no extra cycles between them.
- WR_DATA is sampled only on an accepted write. A byte on the line is unaffected by later writes.

Decomposition:
- Package uart_host_pkg holds:
  - the state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - DATA_BITS=8;
  - a function computing the COUNT width from FIFO_DEPTH.
- One sub-module, uart_host_fifo:
  - a synchronous FIFO with WR_EN/WR_DATA/RD_EN/RD_DATA/FULL/EMPTY/COUNT;
  - RD_DATA is show-ahead (head valid whenever EMPTY=0);
  - it is shared with the planned receive-side monitor.
- The top holds the FSM, divider, shift register and output registers.

Test Plan:
All scenarios use CLK_DIV=16 and STOP_BITS=1 unless stated otherwise.
1. Single write of 0xA5 in idle: TXD low 16 cycles starting 2 edges after the write, then data bits 1,0,1,0,0,1,0,1, then 16 cycles high. TX_DONE pulses once, 160 cycles after TXD falls. BUSY falls the next cycle.
2. Write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles with FIFO_DEPTH=4:
   - The first byte is popped, so 0x05 fits.
   - A 6th write of 0x06 while FULL=1 produces an OVERRUN pulse and is dropped.
   - Five frames go out back-to-back, 800 cycles total with no idle gap.
3. Keep the FIFO topped up for 10 bytes, 0x00..0x09: pointer wrap-around with no lost or reordered bytes, checked by a bench-side UART decoder.
4. Assert RESET for 1 cycle at the 4th data bit of 0xFF with 2 bytes queued: TXD=1 next edge, COUNT=0, BUSY=0, no further frames.
5. STOP_BITS=2 with 0x3C: stop period is 32 cycles high and total frame is 176 cycles.
6. CLK_DIV=2 with bytes 0x55 and 0xAA written: bit timing is exactly 2 cycles per bit and the second frame's start bit immediately follows the first stop bit.
